// File: rtl/prog_logic_cell_if.sv
// ============================================================================
// prog_logic_cell_if : data handshake and serial table-load signals of the
//                      programmable logic cell (cfg_par/cfg_err: PLC_PARITY_EN)
// Revision 1.0
// ============================================================================
`default_nettype none

interface prog_logic_cell_if #(
    parameter int N_IN = 4,
    parameter int N_CH = 1
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [N_CH-1:0] out;
    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_busy;
    logic            cfg_done;
`ifdef PLC_PARITY_EN
    logic            cfg_par;
    logic            cfg_err;
`endif

`ifdef PLC_PARITY_EN
    modport master (
        output in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_bit, cfg_par,
        input  in_ready, out_valid, out, cfg_busy, cfg_done, cfg_err
    );
    modport slave (
        input  in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_bit, cfg_par,
        output in_ready, out_valid, out, cfg_busy, cfg_done, cfg_err
    );
`else
    modport master (
        output in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_bit,
        input  in_ready, out_valid, out, cfg_busy, cfg_done
    );
    modport slave (
        input  in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_bit,
        output in_ready, out_valid, out, cfg_busy, cfg_done
    );
`endif
endinterface

`default_nettype wire

// File: rtl/prog_logic_cell.sv
// ============================================================================
// prog_logic_cell : N-input, multi-channel truth-table logic cell with serial
//                   table load and registered valid/ready output.
//                   Optional table parity check: define PLC_PARITY_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module prog_logic_cell #(
    parameter int                 N_IN     = 4,
    parameter int                 N_CH     = 1,
    parameter logic [2**N_IN-1:0] RESET_TT = 16'hFFFE
) (
    input  wire                   clk,
    input  wire                   rst_n,
    prog_logic_cell_if.slave      bus
);
    localparam int TT    = 2**N_IN;
    localparam int TOTAL = N_CH * TT;
    localparam int CW    = $clog2(TOTAL) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(TOTAL - 1);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [TOTAL-1:0] r_active;
    logic [TOTAL-1:0] r_shadow;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [N_CH-1:0]  r_out;
    logic [N_CH-1:0]  w_lookup;
    logic [TT-1:0]    w_tt [N_CH];
    logic             w_in_ready;
    logic             w_xfer;
    logic             w_last;
    logic             w_commit_ok;
    logic             w_busy;
    logic             w_done;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            assign w_tt[k]     = r_active[k*TT +: TT];
            assign w_lookup[k] = w_tt[k][bus.in_data];
        end
    endgenerate

    assign w_xfer = bus.in_valid && w_in_ready;
    assign w_last = (r_state == S_LOAD) && bus.cfg_valid && (r_cnt == C_LAST);

`ifdef PLC_PARITY_EN
    logic r_par;
    logic w_err;
    // Shadow bits plus the supplied parity must XOR to zero for the load to be accepted.
    assign w_commit_ok = ~((^r_shadow) ^ r_par);
`else
    assign w_commit_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN:    if (bus.cfg_start) w_next = S_LOAD;
            S_LOAD:   if (w_last)        w_next = S_COMMIT;
            S_COMMIT:                    w_next = S_RUN;
            default:                     w_next = S_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
`ifdef PLC_PARITY_EN
        w_err      = 1'b0;
`endif
        case (r_state)
            S_RUN:  w_in_ready = !r_out_valid || bus.out_ready;
            S_LOAD: w_busy     = 1'b1;
            S_COMMIT: begin
                w_busy = 1'b1;
                w_done = w_commit_ok;
`ifdef PLC_PARITY_EN
                w_err  = !w_commit_ok;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out       <= w_lookup;
            r_out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= {N_CH{RESET_TT}};
            r_shadow <= {N_CH{RESET_TT}};
            r_cnt    <= '0;
`ifdef PLC_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            if ((r_state == S_LOAD) && bus.cfg_valid) begin
                r_shadow[r_cnt[CW-2:0]] <= bus.cfg_bit;
                r_cnt                   <= r_cnt + 1'b1;
`ifdef PLC_PARITY_EN
                if (w_last) r_par <= bus.cfg_par;
`endif
            end
            if (r_state == S_COMMIT) begin
                r_cnt <= '0;
                // A rejected load restores the shadow so the next load starts clean.
                if (w_commit_ok) r_active <= r_shadow;
                else             r_shadow <= r_active;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.cfg_busy  = w_busy;
    assign bus.cfg_done  = w_done;
`ifdef PLC_PARITY_EN
    assign bus.cfg_err   = w_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prog_logic_cell.sv
// ============================================================================
// tb_prog_logic_cell : directed-vector bench for prog_logic_cell (1 and 2 channels)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_prog_logic_cell;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prog_logic_cell_if #(.N_IN(4), .N_CH(1)) bus1 ();
    prog_logic_cell_if #(.N_IN(4), .N_CH(2)) bus2 ();

    prog_logic_cell #(.N_IN(4), .N_CH(1), .RESET_TT(16'hFFFE)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    prog_logic_cell #(.N_IN(4), .N_CH(2), .RESET_TT(16'hFFFE)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        logic [3:0] d;
        logic [1:0] exp;
        string      nm;
    } vec_t;

    vec_t v1 [4];
    vec_t v3 [2];
    vec_t v4 [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] g_out(input bit sel);
        return sel ? bus2.out : {1'b0, bus1.out};
    endfunction
    function automatic logic g_valid(input bit sel); return sel ? bus2.out_valid : bus1.out_valid; endfunction
    function automatic logic g_ready(input bit sel); return sel ? bus2.in_ready  : bus1.in_ready;  endfunction
    function automatic logic g_busy (input bit sel); return sel ? bus2.cfg_busy  : bus1.cfg_busy;  endfunction
    function automatic logic g_done (input bit sel); return sel ? bus2.cfg_done  : bus1.cfg_done;  endfunction

    // Streams one vector; in_valid is left high so consecutive calls run at full rate.
    task automatic send(input bit sel, input vec_t v);
        if (sel) begin bus2.in_valid = 1'b1; bus2.in_data = v.d; end
        else     begin bus1.in_valid = 1'b1; bus1.in_data = v.d; end
        chk({v.nm, "_in_ready"}, 32'(g_ready(sel)), 32'd1);
        @(posedge clk); #1;
        chk({v.nm, "_valid"}, 32'(g_valid(sel)), 32'd1);
        chk(v.nm, 32'(g_out(sel)), 32'(v.exp));
    endtask

    task automatic idle(input bit sel);
        if (sel) bus2.in_valid = 1'b0; else bus1.in_valid = 1'b0;
    endtask

    // Starts a load and shifts n bits with random gaps; ends #1 after the last accepted bit.
    task automatic load(input bit sel, input logic [31:0] bits, input int n, input logic par);
        if (sel) bus2.cfg_start = 1'b1; else bus1.cfg_start = 1'b1;
        @(posedge clk); #1;
        bus1.cfg_start = 1'b0;
        bus2.cfg_start = 1'b0;
        chk("load_busy", 32'(g_busy(sel)), 32'd1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            chk("load_in_ready", 32'(g_ready(sel)), 32'd0);
            if (sel) begin bus2.cfg_valid = 1'b1; bus2.cfg_bit = bits[i]; end
            else     begin bus1.cfg_valid = 1'b1; bus1.cfg_bit = bits[i]; end
`ifdef PLC_PARITY_EN
            if (sel) bus2.cfg_par = par; else bus1.cfg_par = par;
`endif
            @(posedge clk); #1;
            bus1.cfg_valid = 1'b0;
            bus2.cfg_valid = 1'b0;
            if (i < n - 1) chk("load_done_early", 32'(g_done(sel)), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        v1[0] = '{4'h0, 2'b00, "t1_d0"};
        v1[1] = '{4'h5, 2'b01, "t1_d5"};
        v1[2] = '{4'hA, 2'b01, "t1_dA"};
        v1[3] = '{4'h8, 2'b01, "t1_d8"};
        v3[0] = '{4'hF, 2'b01, "t3_dF"};
        v3[1] = '{4'hE, 2'b00, "t3_dE"};
        v4[0] = '{4'h0, 2'b00, "t4_rst_d0"};
        v4[1] = '{4'h3, 2'b11, "t4_rst_d3"};
        v4[2] = '{4'h0, 2'b10, "t4_d0"};
        v4[3] = '{4'h1, 2'b01, "t4_d1"};

        bus1.in_valid = 0; bus1.in_data = 0; bus1.out_ready = 1;
        bus1.cfg_start = 0; bus1.cfg_valid = 0; bus1.cfg_bit = 0;
        bus2.in_valid = 0; bus2.in_data = 0; bus2.out_ready = 1;
        bus2.cfg_start = 0; bus2.cfg_valid = 0; bus2.cfg_bit = 0;
`ifdef PLC_PARITY_EN
        bus1.cfg_par = 0; bus2.cfg_par = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(bus1.out), 32'd0);
        chk("rst_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_busy", 32'(bus1.cfg_busy), 32'd0);
        chk("rst_done", 32'(bus1.cfg_done), 32'd0);
        rst_n = 1'b1;

        // Test 1: back-to-back lookups through the reset OR table
        foreach (v1[i]) send(0, v1[i]);
        idle(0);
        @(posedge clk); #1;
        chk("t1_valid_clear", 32'(bus1.out_valid), 32'd0);

        // Test 2: backpressure holds the result
        bus1.out_ready = 1'b0;
        send(0, '{4'h3, 2'b01, "t2_d3"});
        bus1.in_data = 4'h0;
        chk("t2_in_ready", 32'(bus1.in_ready), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("t2_hold_out", 32'(bus1.out), 32'd1);
        chk("t2_hold_valid", 32'(bus1.out_valid), 32'd1);
        idle(0);
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t2_drain", 32'(bus1.out_valid), 32'd0);

        // Test 3: load AND table
        load(0, 32'h0000_8000, 16, 1'b1);
        chk("t3_done", 32'(bus1.cfg_done), 32'd1);
        @(posedge clk); #1;
        chk("t3_done_pulse", 32'(bus1.cfg_done), 32'd0);
        chk("t3_busy_clear", 32'(bus1.cfg_busy), 32'd0);
        foreach (v3[i]) send(0, v3[i]);
        idle(0);

        // Test 4: two channels
        send(1, v4[0]);
        send(1, v4[1]);
        idle(1);
        load(1, {16'h0001, 16'h6996}, 32, 1'b1);
        chk("t4_done", 32'(bus2.cfg_done), 32'd1);
        @(posedge clk); #1;
        send(1, v4[2]);
        send(1, v4[3]);
        idle(1);

        // Test 5: reset in the middle of a load restores the OR table
        load(0, 32'h0, 7, 1'b0);
        chk("t5_busy_mid", 32'(bus1.cfg_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy_async", 32'(bus1.cfg_busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(0, '{4'h2, 2'b01, "t5_d2"});
        idle(0);
        @(posedge clk); #1;

`ifdef PLC_PARITY_EN
        // Test 6: parity rejects, then accepts
        load(0, 32'h0000_8000, 16, 1'b0);
        chk("t6_err", 32'(bus1.cfg_err), 32'd1);
        chk("t6_no_done", 32'(bus1.cfg_done), 32'd0);
        @(posedge clk); #1;
        send(0, '{4'h1, 2'b01, "t6_d1_kept"});
        idle(0);
        load(0, 32'h0000_8000, 16, 1'b1);
        chk("t6_done", 32'(bus1.cfg_done), 32'd1);
        chk("t6_no_err", 32'(bus1.cfg_err), 32'd0);
        @(posedge clk); #1;
        send(0, '{4'h1, 2'b00, "t6_d1_new"});
        idle(0);
        @(posedge clk); #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
